lis3dh_spi_target: RTL and testbench

- SPI target (responder) modelling the LIS3DH register interface; it is the other end of the team's 24-bit LIS3DH SPI master.
- Used in simulation and FPGA loopback as a stand-in accelerometer; also usable as a generic 64x8 SPI register target.
- Oversamples cs_n/spc/sdi on the local clk and serves a 64-byte register file with LIS3DH framing:
  - Command byte: bit7 RW (1 = read), bit6 MS (auto-increment), bits5:0 address.
  - Followed by N data bytes, MSB first, SPI mode 3.

---
 rtl/lis3dh_spi_target.sv | 152 +++++++++++++++
 tb/tb_lis3dh_spi_target.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lis3dh_spi_target.sv
// LIS3DH-style SPI target (mode 3): oversampled on clk, serves a 64x8 register file.
// Command byte = {rw, ms, addr[5:0]}, followed by any number of data bytes, MSB first.
module lis3dh_spi_target #(
  parameter logic [5:0]  WHOAMI_ADDR = 6'h0F,
  parameter logic [7:0]  WHOAMI_VAL  = 8'h33,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cs_n,
  input  logic       spc,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  input  logic       upd_en,
  input  logic [5:0] upd_addr,
  input  logic [7:0] upd_data,
  output logic       wr_strobe,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [SYNC_STAGES-1:0] cs_sync, spc_sync, sdi_sync;
  logic       cs_s, spc_s, sdi_s, spc_d, rise, fall;
  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] cmd_sr, rx_sr;
  logic       rw, ms;
  logic [5:0] addr, cmd_addr, addr_next, tx_addr;
  logic [7:0] tx_byte, tx_val, rx_byte;
  logic       byte_done, spi_we;
  logic [7:0] regs [64];

  // Synchronizers idle at the bus idle levels so reset never looks like a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync  <= '1;
      spc_sync <= '1;
      sdi_sync <= '0;
      spc_d    <= 1'b1;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      spc_sync <= {spc_sync[SYNC_STAGES-2:0], spc};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      spc_d    <= spc_s;
    end
  end

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign spc_s = spc_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];
  assign rise  = spc_s & ~spc_d;
  assign fall  = ~spc_s & spc_d;
  assign busy  = (state != ST_IDLE);

  always_comb begin
    cmd_addr  = {cmd_sr[4:0], sdi_s};
    rx_byte   = {rx_sr, sdi_s};
    addr_next = ms ? addr + 6'd1 : addr;
    tx_addr   = (state == ST_CMD) ? cmd_addr : addr_next;
    tx_val    = (tx_addr == WHOAMI_ADDR) ? WHOAMI_VAL : regs[tx_addr];
    byte_done = !cs_s && (state == ST_DATA) && rise && (bit_cnt == 3'd7);
    spi_we    = byte_done && !rw && (addr != WHOAMI_ADDR);
  end

  // SPI write is assigned last so it overrides a same-cycle host update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 64; i++) regs[i] <= '0;
    end else begin
      if (upd_en && (upd_addr != WHOAMI_ADDR)) regs[upd_addr] <= upd_data;
      if (spi_we) regs[addr] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      cmd_sr     <= '0;
      rx_sr      <= '0;
      rw         <= 1'b0;
      ms         <= 1'b0;
      addr       <= '0;
      tx_byte    <= '0;
      sdo        <= 1'b0;
      sdo_oe     <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_strobe  <= spi_we;
      frame_done <= 1'b0;
      if (spi_we) begin
        wr_addr <= addr;
        wr_data <= rx_byte;
      end
      if (cs_s) begin
        state      <= ST_IDLE;
        bit_cnt    <= '0;
        sdo        <= 1'b0;
        sdo_oe     <= 1'b0;
        frame_done <= (state != ST_IDLE);
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end
          ST_CMD: begin
            if (rise) begin
              cmd_sr  <= {cmd_sr[5:0], sdi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw      <= cmd_sr[6];
                ms      <= cmd_sr[5];
                addr    <= cmd_addr;
                bit_cnt <= '0;
                state   <= ST_DATA;
                if (cmd_sr[6]) tx_byte <= tx_val;
              end
            end
          end
          ST_DATA: begin
            if (rise) begin
              rx_sr   <= {rx_sr[5:0], sdi_s};
              bit_cnt <= bit_cnt + 3'd1;
            end
            // Next byte is snapshotted at the boundary, so host updates never touch the byte in flight.
            if (byte_done) begin
              addr <= addr_next;
              if (rw) tx_byte <= tx_val;
            end
            if (fall && rw) begin
              sdo_oe <= 1'b1;
              sdo    <= tx_byte[3'd7 - bit_cnt];
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lis3dh_spi_target.sv
// Directed bench for lis3dh_spi_target: a mode-3 SPI master task plus strobe/frame monitors.
module tb_lis3dh_spi_target;

  localparam time HALF = 50ns;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n = 1'b1, spc = 1'b1, sdi = 1'b0;
  logic       sdo, sdo_oe;
  logic       upd_en = 1'b0;
  logic [5:0] upd_addr = '0;
  logic [7:0] upd_data = '0;
  logic       wr_strobe, busy, frame_done;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int bit_idx  = -1;
  int fd_cnt   = 0;
  logic [13:0] strobe_q[$];
  logic [31:0] miso, oe;
  logic        got;

  lis3dh_spi_target #(.WHOAMI_ADDR(6'h0F), .WHOAMI_VAL(8'h33), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .spc(spc), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe), .upd_en(upd_en), .upd_addr(upd_addr),
    .upd_data(upd_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .frame_done(frame_done)
  );

  always #5ns clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    strobe_q.delete();
    fd_cnt = 0;
  endtask

  task automatic upd_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    upd_en = 1'b1; upd_addr = a; upd_data = d;
    @(negedge clk);
    upd_en = 1'b0;
  endtask

  // Master drives sdi on the falling edge, samples sdo/sdo_oe just before the rising edge.
  task automatic spi_xfer(input int nbits, input logic [31:0] mosi,
                          output logic [31:0] rx, output logic [31:0] oe_v);
    rx = '0; oe_v = '0;
    @(negedge clk);
    cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      bit_idx = i;
      spc = 1'b0;
      sdi = mosi[nbits-1-i];
      #(HALF);
      rx   = {rx[30:0], sdo};
      oe_v = {oe_v[30:0], sdo_oe};
      spc = 1'b1;
      #(HALF);
    end
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sdo", sdo, 0);
    check("rst_sdo_oe", sdo_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_addr_data", {wr_addr, wr_data}, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);

    // 16-bit write
    clear_mon();
    spi_xfer(16, 32'h2057, miso, oe);
    check("w16_strobes", strobe_q.size(), 1);
    if (strobe_q.size() > 0) check("w16_strobe_val", strobe_q[0], {6'h20, 8'h57});
    check("w16_frame_done", fd_cnt, 1);
    check("w16_busy", busy, 0);
    check("w16_no_oe", oe, 0);
    spi_xfer(16, 32'hA000, miso, oe);
    check("w16_readback", miso[7:0], 8'h57);

    // 24-bit auto-increment read
    upd_write(6'h28, 8'h12);
    upd_write(6'h29, 8'h34);
    clear_mon();
    spi_xfer(24, 32'hE80000, miso, oe);
    check("rd24_data", miso[15:0], 16'h1234);
    check("rd24_oe_window", oe[23:0], 24'h00FFFF);
    check("rd24_oe_after", sdo_oe, 0);
    check("rd24_sdo_after", sdo, 0);
    check("rd24_no_strobe", strobe_q.size(), 0);

    // WHO_AM_I read-only behaviour
    spi_xfer(16, 32'h8F00, miso, oe);
    check("whoami_rd", miso[7:0], 8'h33);
    clear_mon();
    spi_xfer(16, 32'h0FAA, miso, oe);
    check("whoami_wr_no_strobe", strobe_q.size(), 0);
    upd_write(6'h0F, 8'h55);
    spi_xfer(16, 32'h8F00, miso, oe);
    check("whoami_rd_again", miso[7:0], 8'h33);

    // Auto-increment wrap 0x3F -> 0x00
    clear_mon();
    spi_xfer(24, 32'h7F1122, miso, oe);
    check("wrap_strobes", strobe_q.size(), 2);
    if (strobe_q.size() > 1) begin
      check("wrap_strobe0", strobe_q[0], {6'h3F, 8'h11});
      check("wrap_strobe1", strobe_q[1], {6'h00, 8'h22});
    end
    spi_xfer(16, 32'hBF00, miso, oe);
    check("wrap_rd3f", miso[7:0], 8'h11);
    spi_xfer(16, 32'h8000, miso, oe);
    check("wrap_rd00", miso[7:0], 8'h22);

    // Abort mid-byte
    clear_mon();
    spi_xfer(13, {19'd0, 8'h21, 5'b10110}, miso, oe);
    check("abort_no_strobe", strobe_q.size(), 0);
    check("abort_busy", busy, 0);
    check("abort_frame_done", fd_cnt, 1);
    spi_xfer(16, 32'hA100, miso, oe);
    check("abort_reg_unchanged", miso[7:0], 8'h00);
    clear_mon();
    spi_xfer(16, 32'h2166, miso, oe);
    check("post_abort_strobe", strobe_q.size(), 1);
    spi_xfer(24, 32'hA10000, miso, oe);
    check("noinc_repeat_rd", miso[15:0], 16'h6666);

    // Host update colliding with an SPI write to the same register
    clear_mon();
    bit_idx = -1;
    got = 1'b0;
    fork
      spi_xfer(16, 32'h2244, miso, oe);
      begin
        wait (bit_idx == 15 && spc == 1'b0);
        @(negedge clk);
        upd_en = 1'b1; upd_addr = 6'h22; upd_data = 8'h99;
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          if (wr_strobe) begin
            got = 1'b1;
            break;
          end
        end
        upd_en = 1'b0;
      end
    join
    check("collide_strobe_seen", got, 1);
    spi_xfer(16, 32'hA200, miso, oe);
    check("collide_spi_wins", miso[7:0], 8'h44);

    // Snapshot: update during byte 0 shows up in byte 1
    bit_idx = -1;
    fork
      spi_xfer(24, 32'hE80000, miso, oe);
      begin
        wait (bit_idx == 10);
        upd_write(6'h29, 8'h56);
      end
    join
    check("snapshot_rd", miso[15:0], 16'h1256);

    // Command-only frame
    clear_mon();
    spi_xfer(8, 32'h30, miso, oe);
    check("cmd_only_no_strobe", strobe_q.size(), 0);
    check("cmd_only_frame_done", fd_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
